// File: rtl/case_6_mul_pipe.sv
// Signed x signed multiplier with NUM_STAGE registered stages and valid/ready flow control.
// Optional build macro CASE_6_MUL_SAT_EN saturates the stage-1 result instead of wrapping it.
module case_6_mul_pipe #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 12,
  parameter int NUM_STAGE  = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int XW = (PW > dout_WIDTH) ? PW : dout_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The whole pipe freezes while the last stage holds a result nobody takes, so
  // in_ready depends only on the last valid bit and out_ready, never on in_valid.
  logic                         w_stall;
  logic signed [PW-1:0]         w_prod;
  logic signed [XW-1:0]         w_prod_x;
  logic        [dout_WIDTH-1:0] w_res;
  logic                         w_unused;

  logic        [dout_WIDTH-1:0] r_data [NUM_STAGE];
  logic        [NUM_STAGE-1:0]  r_vld;

  assign w_prod   = $signed(din0) * $signed(din1);
  assign w_prod_x = XW'(w_prod);

`ifdef CASE_6_MUL_SAT_EN
  logic signed [XW-1:0] w_max;
  logic signed [XW-1:0] w_min;

  assign w_max = {{(XW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  assign w_min = {{(XW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};

  always_comb begin
    w_res = w_prod_x[dout_WIDTH-1:0];
    if (w_prod_x > w_max) begin
      w_res = w_max[dout_WIDTH-1:0];
    end else if (w_prod_x < w_min) begin
      w_res = w_min[dout_WIDTH-1:0];
    end
  end
`else
  assign w_res = w_prod_x[dout_WIDTH-1:0];
`endif

  // Upper product bits are dropped by the wrap build; ID is only an instance tag.
  assign w_unused = ^{w_prod_x, (ID == 0)};

  assign w_stall   = r_vld[NUM_STAGE-1] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_vld[NUM_STAGE-1];
  assign dout      = r_data[NUM_STAGE-1];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_data[i] <= '0;
      end
    end else if (!w_stall) begin
      // Bubbles advance like data so an idle cycle never costs throughput.
      r_vld[0]  <= in_valid;
      r_data[0] <= w_res;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

endmodule

// File: tb/tb_case_6_mul_pipe.sv
// Bench for case_6_mul_pipe: directed latency/literal cases, stall, reset and random streaming
// against an arithmetic reference of the signed product (wrap or saturate).
module tb_case_6_mul_pipe;

  localparam int W0 = 12;
  localparam int W1 = 7;
  localparam int DW = 12;
  localparam int NS = 2;
  localparam int P  = W0 + W1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;

  int            checks;
  int            errors;
  int            n_out;
  logic [DW-1:0] exp_q[$];
  bit            rand_or;
  bit            or_fixed;
  logic          prev_stall;
  logic [DW-1:0] prev_dout;

  case_6_mul_pipe #(
    .ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW), .NUM_STAGE(NS)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] model(input logic [W0-1:0] a, input logic [W1-1:0] b);
    longint pa;
    longint pb;
    longint p;
    longint lim;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    lim = 0;
`ifdef CASE_6_MUL_SAT_EN
    if (DW < P) begin
      lim = longint'(1) <<< (DW - 1);
      if (p > lim - 1) p = lim - 1;
      else if (p < -lim) p = -lim;
    end
`endif
    return DW'(p + lim - lim);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver: random in the soak phase, otherwise the level the test asks for
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_or ? 1'($urandom_range(0, 1)) : or_fixed;
    end
  end

  // scoreboard / compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_dout", dout, prev_dout);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got %0h expected no result at %0t", dout, $time);
        end else begin
          check("dout", dout, exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(din0, din1));
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
    end
  end

  // drivers: called at posedge+1, return at posedge+1 after the accepting edge
  task automatic send_pair(input logic [W0-1:0] a, input logic [W1-1:0] b);
    bit acc;
    int w;
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    acc = 1'b0;
    w = 0;
    while (!acc && w < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      w++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", w);
    end
    in_valid = 1'b0;
  endtask

  task automatic single_lat(input string name, input logic [W0-1:0] a, input logic [W1-1:0] b,
                            input logic [DW-1:0] expd);
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    @(negedge clk);
    check("single_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int j = 0; j < NS; j++) begin
      @(negedge clk);
      check("latency", out_valid, (j == NS - 1));
      if (j == NS - 1) check(name, dout, expd);
      else @(posedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    check("one_cycle", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    int w;
    checks = 0;
    errors = 0;
    n_out = 0;
    rand_or = 1'b0;
    or_fixed = 1'b1;
    prev_stall = 1'b0;
    prev_dout = '0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    din0 = '0;
    din1 = '0;

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_dout", dout, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // pin the model with hand-computed products
    check("model_neg300", model(12'd100, 7'h7D), 12'hED4);
`ifdef CASE_6_MUL_SAT_EN
    check("model_sat_hi", model(12'h800, 7'h40), 12'h7FF);
    check("model_sat_lo", model(12'h7FF, 7'h40), 12'h800);
`else
    check("model_wrap_hi", model(12'h800, 7'h40), 12'h000);
    check("model_wrap_lo", model(12'h7FF, 7'h40), 12'h040);
`endif

    // directed single pairs with literal results
    single_lat("lit_neg300", 12'd100, 7'h7D, 12'hED4);
`ifdef CASE_6_MUL_SAT_EN
    single_lat("lit_sat_hi", 12'h800, 7'h40, 12'h7FF);
    single_lat("lit_sat_lo", 12'h7FF, 7'h40, 12'h800);
`else
    single_lat("lit_wrap_hi", 12'h800, 7'h40, 12'h000);
    single_lat("lit_wrap_lo", 12'h7FF, 7'h40, 12'h040);
`endif

    // 8 back-to-back pairs -> 8 consecutive results
    fork
      for (int i = 0; i < 8; i++) send_pair(W0'($urandom), W1'($urandom));
    join_none
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("stream_start", out_valid, 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("stream_run", out_valid, 1);
    end
    @(negedge clk);
    check("stream_end", out_valid, 0);
    wait fork;
    @(posedge clk);
    #1;
    wait_drain();

    // stall with a full pipe for 5 cycles, then release
    n0 = n_out;
    or_fixed = 1'b0;
    for (int i = 0; i < NS; i++) send_pair(W0'($urandom), W1'($urandom));
    fork
      send_pair(12'h123, 7'h2A);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    or_fixed = 1'b1;
    wait fork;
    wait_drain();
    check("stall_count", n_out - n0, NS + 1);

    // reset with results in flight
    send_pair(12'd55, 7'd9);
    send_pair(12'h9AB, 7'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_dout", dout, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // random soak
    n0 = n_out;
    rand_or = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
      end
      send_pair(W0'($urandom), W1'($urandom));
    end
    rand_or = 1'b0;
    or_fixed = 1'b1;
    wait_drain();
    check("soak_count", n_out - n0, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
